input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Upstream of game_logic; replaces the raw inversion of player buttons in fightpga.
- Synchronises, debounces and frame-aligns both players' active-low push-buttons.
- Outputs per-frame "held" levels and one-frame "pressed" flags, stable for a whole frame.
- Sits in the clk (VGA pixel clock) domain; frame boundaries come from the VGA vsync output.

Parameters:
- NUM_BUTTONS, 5, buttons per player. Bit map: 0 left, 1 right, 2 light, 3 heavy, 4 block.
- SYNC_STAGES, 2, synchroniser flops per raw input; minimum 2.
- DEBOUNCE_CYCLES, 125000, consecutive clk cycles a new level must persist before it is accepted (5 ms at 25 MHz).
- CNT_W, 17, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  pixel clock from the PLL.
- reset  input  1  synchronous, active-low reset; driven from pll_lock & reset.
- p1_raw  input  NUM_BUTTONS  player 1 pins, asynchronous, active-low (0 = pressed).
- p2_raw  input  NUM_BUTTONS  player 2 pins, same as p1_raw.
- vsync  input  1  VGA vsync, active-low, same clk domain.
- p1_held  output  NUM_BUTTONS  debounced level (1 = pressed), sampled at the last frame strobe.
- p2_held  output  NUM_BUTTONS  same as p1_held, player 2.
- p1_pressed  output  NUM_BUTTONS  1 if a debounced press edge occurred in the previous frame.
- p2_pressed  output  NUM_BUTTONS  same as p1_pressed, player 2.
- frame_strobe  output  1  one-cycle pulse on each vsync falling edge.

Behaviour:
- Reset (reset==0 at a clk edge): all outputs 0.
  - Synchroniser flops load 1 (released), so no spurious press after reset.
  - Debounced state 0, counters 0, pending-press bits 0, vsync delay flop 1.
- Synchroniser: SYNC_STAGES flops per bit; sync output is inverted to active-high (s = ~raw_synced).
- Debounce, per bit, each cycle:
  - If s == stable, counter <= 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1: stable <= s, counter <= 0.
  - Otherwise, counter <= counter+1.
  - Any glitch back to the stable level restarts the count.
  - Latency from pin change to stable: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Edge detect: rise = stable transitions 0->1 this cycle. A rise sets the sticky pending[i] bit.
- Frame strobe:
  - vsync_d <= vsync; frame_strobe = vsync_d & ~vsync (combinational pulse, registered next stage).
  - Outputs update on the cycle after frame_strobe is asserted.
- Output update on a strobe:
  - held <= stable (post-SOCD, see Optional Feature).
  - pressed <= pending | rise_this_cycle.
  - pending <= 0.
  - A rise coincident with the strobe appears in pressed for the new frame and is not also retained in pending.
- Between strobes, held and pressed are constant.
  - game_logic samples them on ~vsync and sees whole-frame-stable values.
- Press-and-release within one frame: held=0, pressed=1 next frame. The press is never lost.
- Multiple presses of one button within a frame collapse into a single pressed=1.
- Release edges are not flagged; they are only visible via held.
- Reset asserted mid-operation: everything returns to reset values on that edge. Pending presses are discarded.
- No state machine beyond per-bit debounce; counters saturate by construction (cleared at DEBOUNCE_CYCLES-1).

Optional Feature:
- Macro: SOCD_CLEAN_EN.
- Defined: when a player's debounced left and right (bits 0 and 1) are both 1, both are forced to 0 in held at the strobe.
  - Press edges of those bits are still reported in pressed.
- Undefined: held passes stable unmodified; both directions may read 1.

Decomposition:
- params.vh gains:
  - BTN_LEFT=0, BTN_RIGHT=1, BTN_LIGHT=2, BTN_HEAVY=3, BTN_BLOCK=4.
  - NUM_BUTTONS.
  - DEBOUNCE_CYCLES and CNT_W defaults.
- Sub-module button_debounce (synchroniser + counter + stable + rise), instantiated 2*NUM_BUTTONS times.
- Frame strobe, pending and output registers live in input_conditioner.

Test Plan (use DEBOUNCE_CYCLES=8 in the bench):
- Reset with p1_raw=5'b11111 -> all outputs 0; after 3 frames still 0.
- p1_raw[2] held low for 20 cycles mid-frame -> next strobe: p1_pressed=5'b00100, p1_held=5'b00100; following strobe: p1_pressed=0, p1_held=5'b00100.
- p2_raw[0] pulses low for 6 cycles (< debounce) -> p2_held and p2_pressed stay 0.
- p1_raw[4] low for 12 cycles then high, all within one frame -> next strobe: p1_pressed[4]=1, p1_held[4]=0.
- Debounce completes on the exact strobe cycle -> pressed bit is 1 in that frame only, not repeated next frame.
- p1_raw[1:0]=2'b00 held -> with SOCD_CLEAN_EN: p1_held[1:0]=00 and p1_pressed[1:0]=11; without it: p1_held[1:0]=11.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// input_conditioner_pkg
// Shared definitions for the player input conditioning path.
//   - btn_e            : bit positions of the buttons inside a player vector
//   - *_DEF            : default sizing for the conditioner and its debouncers
//   - socd_clean()     : resolves simultaneous left+right into neither
// Configuration macro: SOCD_CLEAN_EN (consumed by input_conditioner).
// -----------------------------------------------------------------------------
package input_conditioner_pkg;

  // Bit positions of each button inside a per-player vector.
  typedef enum int unsigned {
    BTN_LEFT  = 32'd0,
    BTN_RIGHT = 32'd1,
    BTN_LIGHT = 32'd2,
    BTN_HEAVY = 32'd3,
    BTN_BLOCK = 32'd4
  } btn_e;

  localparam int unsigned NUM_BUTTONS_DEF     = 32'd5;
  localparam int unsigned SYNC_STAGES_DEF     = 32'd2;
  // 5 ms at a 25 MHz pixel clock.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd125000;
  // 2^17 = 131072 > 125000, so the counter never wraps.
  localparam int unsigned CNT_W_DEF           = 32'd17;

  // Opposite directions held together cancel out: {right,left} = 11 -> 00.
  function automatic logic [1:0] socd_clean(input logic [1:0] right_left);
    logic [1:0] result;
    if (right_left == 2'b11) begin
      result = 2'b00;
    end else begin
      result = right_left;
    end
    return result;
  endfunction

endpackage

// File: rtl/input_conditioner_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// One active-low push-button: synchroniser, persistence counter, accepted
// (stable) level and a single-cycle press indication.
// Ports:
//   clk     in  pixel clock
//   reset   in  synchronous, active-low reset
//   raw     in  asynchronous pin level, 0 = pressed
//   stable  out debounced level, 1 = pressed (registered)
//   rise    out 1 on the cycle whose closing edge moves stable from 0 to 1
// A new level is accepted only after it has been seen on DEBOUNCE_CYCLES
// consecutive clk edges; any return to the accepted level restarts the count.
// -----------------------------------------------------------------------------
module button_debounce
  import input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   stable_r;

  logic                   level_s;
  logic [CNT_W-1:0]       cnt_next_s;
  logic                   stable_next_s;

  // Synchroniser chain; loads 1 (released) so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
    end
  end

  // Pins are active-low; everything downstream works in pressed = 1.
  assign level_s = ~sync_r[SYNC_STAGES-1];

  // Persistence counter: count while the synced level disagrees with stable.
  always_comb begin
    cnt_next_s    = cnt_r;
    stable_next_s = stable_r;
    if (level_s == stable_r) begin
      cnt_next_s = CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      // Clearing here keeps the counter inside 0..DEBOUNCE_CYCLES-1.
      stable_next_s = level_s;
      cnt_next_s    = CNT_ZERO;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r    <= CNT_ZERO;
      stable_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_next_s;
      stable_r <= stable_next_s;
    end
  end

  assign stable = stable_r;
  // Combinational so the frame logic can catch a press that lands on a strobe.
  assign rise   = stable_next_s & ~stable_r;

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Synchronises, debounces and frame-aligns both players' active-low buttons
// so game_logic sees values that are constant for a whole video frame.
// Ports:
//   clk           in  pixel clock
//   reset         in  synchronous, active-low reset
//   p1_raw        in  [NUM_BUTTONS] player 1 pins, async, 0 = pressed
//   p2_raw        in  [NUM_BUTTONS] player 2 pins, async, 0 = pressed
//   vsync         in  VGA vsync, active-low, clk domain
//   p1_held       out [NUM_BUTTONS] debounced level captured at last strobe
//   p2_held       out [NUM_BUTTONS] same for player 2
//   p1_pressed    out [NUM_BUTTONS] press edge seen during the previous frame
//   p2_pressed    out [NUM_BUTTONS] same for player 2
//   frame_strobe  out one-cycle pulse on each vsync falling edge
// Configuration macro: SOCD_CLEAN_EN -- when defined, left+right held together
// reads as neither in *_held (press edges are still reported).
// -----------------------------------------------------------------------------
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = NUM_BUTTONS_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] p1_raw,
  input  logic [NUM_BUTTONS-1:0] p2_raw,
  input  logic                   vsync,
  output logic [NUM_BUTTONS-1:0] p1_held,
  output logic [NUM_BUTTONS-1:0] p2_held,
  output logic [NUM_BUTTONS-1:0] p1_pressed,
  output logic [NUM_BUTTONS-1:0] p2_pressed,
  output logic                   frame_strobe
);

  localparam logic [NUM_BUTTONS-1:0] BTN_NONE = {NUM_BUTTONS{1'b0}};

  logic [NUM_BUTTONS-1:0] p1_stable_s;
  logic [NUM_BUTTONS-1:0] p2_stable_s;
  logic [NUM_BUTTONS-1:0] p1_rise_s;
  logic [NUM_BUTTONS-1:0] p2_rise_s;
  logic [NUM_BUTTONS-1:0] p1_clean_s;
  logic [NUM_BUTTONS-1:0] p2_clean_s;

  logic                   vsync_d_r;
  logic                   strobe_s;

  logic [NUM_BUTTONS-1:0] p1_pending_r;
  logic [NUM_BUTTONS-1:0] p2_pending_r;
  logic [NUM_BUTTONS-1:0] p1_held_r;
  logic [NUM_BUTTONS-1:0] p2_held_r;
  logic [NUM_BUTTONS-1:0] p1_pressed_r;
  logic [NUM_BUTTONS-1:0] p2_pressed_r;

  // Left/right resolution applied to the level captured into *_held.
  function automatic logic [NUM_BUTTONS-1:0] held_view(input logic [NUM_BUTTONS-1:0] st);
    logic [NUM_BUTTONS-1:0] view;
    view = st;
`ifdef SOCD_CLEAN_EN
    {view[BTN_RIGHT], view[BTN_LEFT]} = socd_clean({st[BTN_RIGHT], st[BTN_LEFT]});
`else
    view = st;
`endif
    return view;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      button_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_p1 (
        .clk    (clk),
        .reset  (reset),
        .raw    (p1_raw[gi]),
        .stable (p1_stable_s[gi]),
        .rise   (p1_rise_s[gi])
      );

      button_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_p2 (
        .clk    (clk),
        .reset  (reset),
        .raw    (p2_raw[gi]),
        .stable (p2_stable_s[gi]),
        .rise   (p2_rise_s[gi])
      );
    end
  endgenerate

  // Falling-edge detect on vsync; masked during reset so outputs read 0 there.
  assign strobe_s = vsync_d_r & ~vsync & reset;

  // Held-level view for each player at the coming strobe.
  always_comb begin
    p1_clean_s = held_view(p1_stable_s);
    p2_clean_s = held_view(p2_stable_s);
  end

  // vsync delay, sticky press capture and per-frame output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vsync_d_r    <= 1'b1;
      p1_pending_r <= BTN_NONE;
      p2_pending_r <= BTN_NONE;
      p1_held_r    <= BTN_NONE;
      p2_held_r    <= BTN_NONE;
      p1_pressed_r <= BTN_NONE;
      p2_pressed_r <= BTN_NONE;
    end else begin
      vsync_d_r <= vsync;
      if (strobe_s) begin
        // A rise on the strobe cycle goes straight into the new frame's
        // pressed flags and is not carried over in pending.
        p1_held_r    <= p1_clean_s;
        p2_held_r    <= p2_clean_s;
        p1_pressed_r <= p1_pending_r | p1_rise_s;
        p2_pressed_r <= p2_pending_r | p2_rise_s;
        p1_pending_r <= BTN_NONE;
        p2_pending_r <= BTN_NONE;
      end else begin
        p1_held_r    <= p1_held_r;
        p2_held_r    <= p2_held_r;
        p1_pressed_r <= p1_pressed_r;
        p2_pressed_r <= p2_pressed_r;
        p1_pending_r <= p1_pending_r | p1_rise_s;
        p2_pending_r <= p2_pending_r | p2_rise_s;
      end
    end
  end

  assign p1_held      = p1_held_r;
  assign p2_held      = p2_held_r;
  assign p1_pressed   = p1_pressed_r;
  assign p2_pressed   = p2_pressed_r;
  assign frame_strobe = strobe_s;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES = 8.
// A behavioural model (sliding window of the last 8 synced samples per button)
// is compared every cycle; scenario tables and hand sequences check fixed
// expectations at frame boundaries. Honours SOCD_CLEAN_EN like the design.
// -----------------------------------------------------------------------------
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int NB    = 5;
  localparam int SS    = 2;
  localparam int DEB   = 8;
  localparam int CW    = 4;
  localparam int FRAME = 64;
  localparam int VLOW  = 4;

`ifdef SOCD_CLEAN_EN
  localparam logic [NB-1:0] SOCD_HELD = 5'b00000;
`else
  localparam logic [NB-1:0] SOCD_HELD = 5'b00011;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync;
  logic [NB-1:0] p1_raw, p2_raw;
  logic [NB-1:0] p1_held, p2_held, p1_pressed, p2_pressed;
  logic          frame_strobe;

  always #5 clk = ~clk;

  input_conditioner #(
    .NUM_BUTTONS     (NB),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .p1_raw       (p1_raw),
    .p2_raw       (p2_raw),
    .vsync        (vsync),
    .p1_held      (p1_held),
    .p2_held      (p2_held),
    .p1_pressed   (p1_pressed),
    .p2_pressed   (p2_pressed),
    .frame_strobe (frame_strobe)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int fc = 0;        // next vsync pattern index to apply
  int last_idx = 0;  // index applied by the latest step

  // Reference model state
  logic [NB-1:0]  m_q [2][SS];   // raw samples in flight toward the debouncer
  logic [DEB-1:0] m_win [2][NB]; // last DEB synced (pressed=1) samples
  logic [NB-1:0]  m_stable [2];
  logic [NB-1:0]  m_pend [2];
  logic [NB-1:0]  m_held [2];
  logic [NB-1:0]  m_press [2];
  logic           m_vd;

  typedef struct packed {
    logic [NB-1:0] m1, m2;   // buttons pushed (1 = drive pin low)
    int            low;      // cycles pushed
    bit            rel;      // release before the first check
    logic [NB-1:0] a1h, a1p, a2h, a2p;  // after next strobe
    logic [NB-1:0] b1h, b1p, b2h, b2p;  // after the following strobe
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Applies one clock edge of the specification's rules to the model.
  task automatic model_edge();
    logic [NB-1:0] raw [2];
    logic          strobe;
    logic [NB-1:0] nst, rise, clean;
    raw[0] = p1_raw;
    raw[1] = p2_raw;
    if (!reset) begin
      for (int p = 0; p < 2; p++) begin
        for (int k = 0; k < SS; k++) m_q[p][k] = '1;
        for (int b = 0; b < NB; b++) m_win[p][b] = '0;
        m_stable[p] = '0; m_pend[p] = '0; m_held[p] = '0; m_press[p] = '0;
      end
      m_vd = 1'b1;
    end else begin
      strobe = m_vd & ~vsync;
      for (int p = 0; p < 2; p++) begin
        nst  = m_stable[p];
        rise = '0;
        for (int b = 0; b < NB; b++) begin
          m_win[p][b] = {m_win[p][b][DEB-2:0], ~m_q[p][SS-1][b]};
          // accept the opposite level once all DEB recent samples show it
          if (m_stable[p][b] ? (m_win[p][b] == '0) : (m_win[p][b] == '1)) begin
            nst[b]  = ~m_stable[p][b];
            rise[b] = ~m_stable[p][b];
          end
        end
        clean = m_stable[p];
`ifdef SOCD_CLEAN_EN
        if (clean[1:0] == 2'b11) clean[1:0] = 2'b00;
`endif
        if (strobe) begin
          m_held[p]  = clean;
          m_press[p] = m_pend[p] | rise;
          m_pend[p]  = '0;
        end else begin
          m_pend[p] = m_pend[p] | rise;
        end
        m_stable[p] = nst;
        for (int k = SS - 1; k > 0; k--) m_q[p][k] = m_q[p][k-1];
        m_q[p][0] = raw[p];
      end
      m_vd = vsync;
    end
  endtask

  // One clock: model update, compare, then advance the vsync pattern.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (chk_en) begin
      chk("model p1_held", p1_held, m_held[0]);
      chk("model p2_held", p2_held, m_held[1]);
      chk("model p1_pressed", p1_pressed, m_press[0]);
      chk("model p2_pressed", p2_pressed, m_press[1]);
      chk("model frame_strobe", {4'b0000, frame_strobe}, {4'b0000, m_vd & ~vsync & reset});
    end
    vsync    = (fc < VLOW) ? 1'b0 : 1'b1;
    last_idx = fc;
    fc       = (fc + 1) % FRAME;
  endtask

  // Advance until pattern index n has just been applied (at most one frame).
  task automatic to_index(input int n);
    do step(); while (last_idx != n);
  endtask

  task automatic chk_out(input string nm, input logic [NB-1:0] e1h, input logic [NB-1:0] e1p,
                         input logic [NB-1:0] e2h, input logic [NB-1:0] e2p);
    chk({nm, " p1_held"}, p1_held, e1h);
    chk({nm, " p1_pressed"}, p1_pressed, e1p);
    chk({nm, " p2_held"}, p2_held, e2h);
    chk({nm, " p2_pressed"}, p2_pressed, e2p);
  endtask

  task automatic release_settle();
    p1_raw = '1;
    p2_raw = '1;
    to_index(1);
    to_index(1);
  endtask

  function automatic vec_t mk(input logic [NB-1:0] m1, input logic [NB-1:0] m2, input int low,
                              input bit rel, input logic [NB-1:0] a1h, input logic [NB-1:0] a1p,
                              input logic [NB-1:0] a2h, input logic [NB-1:0] a2p,
                              input logic [NB-1:0] b1h, input logic [NB-1:0] b1p,
                              input logic [NB-1:0] b2h, input logic [NB-1:0] b2p);
    vec_t v;
    v.m1 = m1; v.m2 = m2; v.low = low; v.rel = rel;
    v.a1h = a1h; v.a1p = a1p; v.a2h = a2h; v.a2p = a2p;
    v.b1h = b1h; v.b1p = b1p; v.b2h = b2h; v.b2p = b2p;
    return v;
  endfunction

  initial begin
    // held press -> held and pressed, then held only
    tbl[0] = mk(5'b00100, 5'b00000, 20, 1'b0, 5'b00100, 5'b00100, 5'b0, 5'b0,
                5'b00100, 5'b00000, 5'b0, 5'b0);
    // 6-cycle glitch is shorter than the debounce window
    tbl[1] = mk(5'b00000, 5'b00001, 6, 1'b1, 5'b0, 5'b0, 5'b0, 5'b0,
                5'b0, 5'b0, 5'b0, 5'b0);
    // press and release inside one frame is still reported
    tbl[2] = mk(5'b10000, 5'b00000, 12, 1'b1, 5'b00000, 5'b10000, 5'b0, 5'b0,
                5'b0, 5'b0, 5'b0, 5'b0);
    // left+right together
    tbl[3] = mk(5'b00011, 5'b00000, 20, 1'b0, SOCD_HELD, 5'b00011, 5'b0, 5'b0,
                SOCD_HELD, 5'b00000, 5'b0, 5'b0);
    // both players, several buttons
    tbl[4] = mk(5'b01000, 5'b10110, 20, 1'b0, 5'b01000, 5'b01000, 5'b10110, 5'b10110,
                5'b01000, 5'b00000, 5'b10110, 5'b00000);
    // 3-cycle glitches on both players
    tbl[5] = mk(5'b00101, 5'b00011, 3, 1'b1, 5'b0, 5'b0, 5'b0, 5'b0,
                5'b0, 5'b0, 5'b0, 5'b0);

    reset  = 1'b0;
    vsync  = 1'b1;
    p1_raw = 5'b11111;
    p2_raw = 5'b11111;
    step();
    chk_en = 1'b1;
    step();
    chk_out("reset", 5'b0, 5'b0, 5'b0, 5'b0);
    chk("reset frame_strobe", {4'b0000, frame_strobe}, 5'b00000);

    reset = 1'b1;
    to_index(1);
    to_index(1);
    to_index(1);
    chk_out("idle 3 frames", 5'b0, 5'b0, 5'b0, 5'b0);

    for (int i = 0; i < 6; i++) begin
      to_index(5);
      p1_raw = ~tbl[i].m1;
      p2_raw = ~tbl[i].m2;
      for (int c = 0; c < tbl[i].low; c++) step();
      if (tbl[i].rel) begin
        p1_raw = '1;
        p2_raw = '1;
      end
      to_index(1);
      chk_out($sformatf("vec%0d frame A", i), tbl[i].a1h, tbl[i].a1p, tbl[i].a2h, tbl[i].a2p);
      to_index(1);
      chk_out($sformatf("vec%0d frame B", i), tbl[i].b1h, tbl[i].b1p, tbl[i].b2h, tbl[i].b2p);
      release_settle();
    end

    // debounce completes on the exact strobe edge
    to_index(55);
    p2_raw[3] = 1'b0;
    to_index(1);
    chk_out("on-strobe frame A", 5'b0, 5'b0, 5'b00000, 5'b01000);
    to_index(1);
    chk_out("on-strobe frame B", 5'b0, 5'b0, 5'b01000, 5'b00000);
    release_settle();

    // debounce completes one edge after the strobe: reported a frame later
    to_index(56);
    p2_raw[3] = 1'b0;
    to_index(1);
    chk_out("post-strobe frame A", 5'b0, 5'b0, 5'b00000, 5'b00000);
    to_index(1);
    chk_out("post-strobe frame B", 5'b0, 5'b0, 5'b01000, 5'b01000);
    release_settle();

    // reset mid-frame discards a pending press
    to_index(5);
    p1_raw[2] = 1'b0;
    for (int c = 0; c < 20; c++) step();
    p1_raw = '1;
    reset  = 1'b0;
    step();
    chk_out("mid reset", 5'b0, 5'b0, 5'b0, 5'b0);
    reset = 1'b1;
    to_index(1);
    chk_out("after mid reset", 5'b0, 5'b0, 5'b0, 5'b0);

    // random toggling with occasional resets, checked against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = $urandom_range(0, NB - 1);
        if ($urandom_range(0, 1) == 0) p1_raw[b] = ~p1_raw[b];
        else                           p2_raw[b] = ~p2_raw[b];
      end
      reset = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
